// File: rtl/nios_system_mul_pipe.sv
// nios_system_mul_pipe
//   Two-stage pipelined DATA_W x DATA_W multiplier / multiply-accumulate.
//   The full 2*DATA_W product is built from four (HALF_W+1)-bit signed
//   partial products. Each operand is independently signed or unsigned.
//   A 2*DATA_W accumulator supports MAC. One half of the result is returned
//   per operation over a valid/ready stream, in order, with its tag.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake
//   in_src1/in_src2     operands; in_src*_signed selects two's complement
//   in_op               00 MUL, 01 ACC_LOAD, 10 ACC_ADD, 11 behaves as MUL
//   in_hi               1 = upper DATA_W bits of the result, 0 = lower
//   in_tag              opaque tag, returned with the result
//   out_valid/out_ready result handshake
//   out_result/out_tag  selected result half and its tag
module nios_system_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic              in_src1_signed,
  input  logic              in_src2_signed,
  input  logic [1:0]        in_op,
  input  logic              in_hi,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PP_W   = DATA_W + 2;   // (HALF_W+1) x (HALF_W+1) signed product
  localparam int P_W    = 2 * DATA_W;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

  typedef struct packed {
    logic [1:0]       op;
    logic             hi;
    logic [TAG_W-1:0] tag;
    logic [PP_W-1:0]  p_ll;
    logic [PP_W-1:0]  p_lh;
    logic [PP_W-1:0]  p_hl;
    logic [PP_W-1:0]  p_hh;
  } s1_t;

  // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 (output) valid
  logic [2:1]      vld_pipe;
  logic            s0_vld;
  logic            en;
  s1_t             s1_d, s1_q;
  logic [P_W-1:0]  acc;

  // One global advance: nothing moves while a result is held unconsumed.
  assign en        = !vld_pipe[2] || out_ready;
  assign in_ready  = en && !reset;
  assign s0_vld    = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  // ---------------- stage 1: halves and partial products ----------------
  // Low halves are always magnitudes; only the high half carries the sign,
  // so one extra bit per half makes every partial product a plain signed
  // multiply regardless of the operand signedness mix.
  logic signed [HALF_W:0] lo1, hi1, lo2, hi2;
  logic signed [PP_W-1:0] m_ll, m_lh, m_hl, m_hh;

  always_comb begin
    lo1  = $signed({1'b0, in_src1[HALF_W-1:0]});
    lo2  = $signed({1'b0, in_src2[HALF_W-1:0]});
    hi1  = $signed({in_src1_signed & in_src1[DATA_W-1], in_src1[DATA_W-1:HALF_W]});
    hi2  = $signed({in_src2_signed & in_src2[DATA_W-1], in_src2[DATA_W-1:HALF_W]});
    m_ll = lo1 * lo2;
    m_lh = lo1 * hi2;
    m_hl = hi1 * lo2;
    m_hh = hi1 * hi2;
    s1_d      = '0;
    s1_d.op   = in_op;
    s1_d.hi   = in_hi;
    s1_d.tag  = in_tag;
    s1_d.p_ll = m_ll;
    s1_d.p_lh = m_lh;
    s1_d.p_hl = m_hl;
    s1_d.p_hh = m_hh;
  end

  // ---------------- stage 2: recombine, accumulate, select ----------------
  logic [P_W-1:0]    e_ll, e_lh, e_hl, e_hh;
  logic [P_W-1:0]    prod, acc_sum, res;
  logic [DATA_W-1:0] res_half;

  always_comb begin
    e_ll     = {{(P_W-PP_W){s1_q.p_ll[PP_W-1]}}, s1_q.p_ll};
    e_lh     = {{(P_W-PP_W){s1_q.p_lh[PP_W-1]}}, s1_q.p_lh};
    e_hl     = {{(P_W-PP_W){s1_q.p_hl[PP_W-1]}}, s1_q.p_hl};
    e_hh     = {{(P_W-PP_W){s1_q.p_hh[PP_W-1]}}, s1_q.p_hh};
    // All terms wrap modulo 2^P_W, which is exactly the product width.
    prod     = (e_hh << DATA_W) + ((e_lh + e_hl) << HALF_W) + e_ll;
    acc_sum  = acc + prod;
    res      = (s1_q.op == OP_ADD) ? acc_sum : prod;
    res_half = s1_q.hi ? res[P_W-1:DATA_W] : res[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      acc        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (en) begin
      vld_pipe[1] <= s0_vld;
      vld_pipe[2] <= vld_pipe[1];
      if (s0_vld) s1_q <= s1_d;
      // The accumulator only moves when a real op crosses into S2, so a
      // stalled op touches it exactly once and bubbles never do.
      if (vld_pipe[1]) begin
        out_result <= res_half;
        out_tag    <= s1_q.tag;
        case (s1_q.op)
          OP_LOAD: acc <= prod;
          OP_ADD:  acc <= acc_sum;
          OP_MUL:  acc <= acc;
          default: acc <= acc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_system_mul_pipe.sv
module tb_nios_system_mul_pipe;

  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_src1, in_src2;
  logic          in_src1_signed, in_src2_signed;
  logic [1:0]    in_op;
  logic          in_hi;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;

  nios_system_mul_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2),
    .in_src1_signed(in_src1_signed), .in_src2_signed(in_src2_signed),
    .in_op(in_op), .in_hi(in_hi), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sa;
    logic          sb;
    logic [1:0]    op;
    logic          hi;
    logic [TW-1:0] tag;
  } stim_t;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  localparam logic [1:0] MUL = 2'b00, LOAD = 2'b01, ADD = 2'b10;

  exp_t          q[$];
  logic [63:0]   m_acc;
  int            total, bad;
  stim_t         idle;

  // Reference: plain 64-bit multiply of the extended operands.
  function automatic logic [DW-1:0] model(input stim_t s);
    logic [63:0] a, b, p, r;
    a = s.sa ? {{32{s.a[31]}}, s.a} : {32'h0, s.a};
    b = s.sb ? {{32{s.b[31]}}, s.b} : {32'h0, s.b};
    p = a * b;
    r = p;
    case (s.op)
      LOAD: begin m_acc = p; r = p; end
      ADD:  begin m_acc = m_acc + p; r = m_acc; end
      default: r = p;
    endcase
    return s.hi ? r[63:32] : r[31:0];
  endfunction

  // Drive one cycle; report pre-edge handshake state, push expectations
  // for accepted ops, then advance to 1 time unit after the next edge.
  task automatic cycle(input logic v, input stim_t s, input logic ordy,
                       output logic acc, output logic ov, output logic ir,
                       output logic [DW-1:0] r, output logic [TW-1:0] t);
    in_valid = v; in_src1 = s.a; in_src2 = s.b;
    in_src1_signed = s.sa; in_src2_signed = s.sb;
    in_op = s.op; in_hi = s.hi; in_tag = s.tag; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    ir  = in_ready;
    r   = out_result;
    t   = out_tag;
    if (acc) q.push_back('{model(s), s.tag});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_src1 = 32'd7; in_src2 = 32'd9; in_op = MUL; in_tag = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    m_acc = '0;
  endtask

  task automatic test_latency();
    logic a, ov, ir; logic [DW-1:0] r; logic [TW-1:0] t; exp_t e;
    cycle(1'b1, '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MUL, 1'b0, 4'h9}, 1'b1, a, ov, ir, r, t);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL lat_accept: got %b want 1", a); end
    cycle(1'b0, idle, 1'b1, a, ov, ir, r, t);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL lat_early: out_valid got %b want 0 one edge after accept", ov); end
    cycle(1'b0, idle, 1'b1, a, ov, ir, r, t);
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL lat_valid: out_valid got %b want 1 two edges after accept", ov); end
    if (ov && q.size() > 0) begin
      e = q.pop_front();
      total++; if (r !== 32'h00000001 || t !== e.tag) begin bad++; $display("FAIL lat_result: got %h/%h want 00000001/%h", r, t, e.tag); end
    end
    q.delete();
  endtask

  task automatic test_mul();
    stim_t tbl [6];
    int n; logic a, ov, ir; logic [DW-1:0] r; logic [TW-1:0] t; exp_t e;
    tbl = '{
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MUL, 1'b0, 4'h1},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MUL, 1'b1, 4'h2},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, MUL, 1'b1, 4'h3},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, MUL, 1'b1, 4'h4},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b11, 1'b0, 4'h5},
      '{32'h80000000, 32'h80000000, 1'b1, 1'b1, MUL, 1'b1, 4'h6}
    };
    n = 0;
    for (int c = 0; c < 40 && (n < 6 || q.size() > 0); c++) begin
      cycle(n < 6, tbl[n < 6 ? n : 0], 1'b1, a, ov, ir, r, t);
      if (a) n++;
      if (ov) begin
        if (q.size() == 0) begin total++; bad++; $display("FAIL mul_extra: got %h/%h want none", r, t); end
        else begin
          e = q.pop_front(); total++;
          if (r !== e.res || t !== e.tag) begin bad++; $display("FAIL mul_result: got %h/%h want %h/%h", r, t, e.res, e.tag); end
        end
      end
    end
    if (q.size() != 0 || n != 6) begin total++; bad++; $display("FAIL mul_timeout: issued %0d pending %0d want 6/0", n, q.size()); q.delete(); end
  endtask

  task automatic test_backpressure();
    stim_t s;
    int n; logic ordy, a, ov, ir, stalled; logic [DW-1:0] r, pr; logic [TW-1:0] t, pt; exp_t e;
    n = 0; stalled = 1'b0; pr = '0; pt = '0;
    for (int c = 0; c < 40 && (n < 4 || q.size() > 0); c++) begin
      s = '{DW'(n + 1), 32'd3, 1'b0, 1'b0, MUL, 1'b0, TW'(n)};
      ordy = !(c >= 2 && c <= 4);
      cycle(n < 4, s, ordy, a, ov, ir, r, t);
      if (a) n++;
      if (!ordy && ov) begin
        total++; if (ir !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0 while stalled", ir); end
        if (stalled) begin
          total++; if (r !== pr || t !== pt) begin bad++; $display("FAIL bp_hold: got %h/%h want %h/%h", r, t, pr, pt); end
        end
        stalled = 1'b1; pr = r; pt = t;
      end else stalled = 1'b0;
      if (ov && ordy) begin
        if (q.size() == 0) begin total++; bad++; $display("FAIL bp_extra: got %h/%h want none", r, t); end
        else begin
          e = q.pop_front(); total++;
          if (r !== e.res || t !== e.tag) begin bad++; $display("FAIL bp_result: got %h/%h want %h/%h", r, t, e.res, e.tag); end
        end
      end
    end
    if (q.size() != 0 || n != 4) begin total++; bad++; $display("FAIL bp_timeout: issued %0d pending %0d want 4/0", n, q.size()); q.delete(); end
  endtask

  task automatic test_mac_wrap();
    stim_t tbl [10];
    int n; logic a, ov, ir; logic [DW-1:0] r; logic [TW-1:0] t; exp_t e;
    tbl = '{
      '{32'd3, 32'd4, 1'b0, 1'b0, LOAD, 1'b0, 4'h0},
      '{32'd5, 32'd6, 1'b0, 1'b0, ADD,  1'b0, 4'h1},
      '{32'hFFFFFFFE, 32'd7, 1'b1, 1'b1, ADD, 1'b0, 4'h2},
      '{32'd2, 32'd2, 1'b0, 1'b0, MUL,  1'b0, 4'h3},
      '{32'd0, 32'd0, 1'b0, 1'b0, ADD,  1'b0, 4'h4},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, LOAD, 1'b0, 4'h5},
      '{32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, ADD, 1'b1, 4'h6},
      '{32'd0, 32'd0, 1'b0, 1'b0, ADD, 1'b0, 4'h7},
      '{32'd1, 32'd1, 1'b0, 1'b0, ADD, 1'b1, 4'h8},
      '{32'd0, 32'd0, 1'b0, 1'b0, ADD, 1'b0, 4'h9}
    };
    n = 0;
    for (int c = 0; c < 60 && (n < 10 || q.size() > 0); c++) begin
      cycle(n < 10, tbl[n < 10 ? n : 0], (c % 3) != 2, a, ov, ir, r, t);
      if (a) n++;
      if (ov && (c % 3) != 2) begin
        if (q.size() == 0) begin total++; bad++; $display("FAIL mac_extra: got %h/%h want none", r, t); end
        else begin
          e = q.pop_front(); total++;
          if (r !== e.res || t !== e.tag) begin bad++; $display("FAIL mac_result: got %h/%h want %h/%h", r, t, e.res, e.tag); end
        end
      end
    end
    if (q.size() != 0 || n != 10) begin total++; bad++; $display("FAIL mac_timeout: issued %0d pending %0d want 10/0", n, q.size()); q.delete(); end
  endtask

  task automatic test_reset_flight();
    int n; logic a, ov, ir; logic [DW-1:0] r; logic [TW-1:0] t; exp_t e;
    cycle(1'b1, '{32'd5, 32'd5, 1'b0, 1'b0, LOAD, 1'b0, 4'hA}, 1'b0, a, ov, ir, r, t);
    cycle(1'b1, '{32'd6, 32'd6, 1'b0, 1'b0, ADD,  1'b0, 4'hB}, 1'b0, a, ov, ir, r, t);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_in_ready_in_reset: got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); m_acc = '0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_out_valid: got %b want 0", out_valid); end
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_in_ready_after: got %b want 1", in_ready); end
    n = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(n < 1, '{32'd1, 32'd1, 1'b0, 1'b0, ADD, 1'b0, 4'hC}, 1'b1, a, ov, ir, r, t);
      if (a) n++;
      if (ov) begin
        if (q.size() == 0) begin total++; bad++; $display("FAIL rf_stale: got %h/%h want none", r, t); end
        else begin
          e = q.pop_front(); total++;
          if (r !== e.res || t !== e.tag) begin bad++; $display("FAIL rf_result: got %h/%h want %h/%h", r, t, e.res, e.tag); end
        end
      end
    end
    if (q.size() != 0 || n != 1) begin total++; bad++; $display("FAIL rf_timeout: issued %0d pending %0d want 1/0", n, q.size()); q.delete(); end
  endtask

  initial begin
    total = 0; bad = 0; m_acc = '0; idle = '0;
    in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_src1_signed = 1'b0; in_src2_signed = 1'b0;
    in_op = MUL; in_hi = 1'b0; in_tag = '0; out_ready = 1'b0; reset = 1'b1;
    test_reset();
    test_latency();
    test_mul();
    test_backpressure();
    test_mac_wrap();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_system_mul_pipe.md
# nios_system_mul_pipe

Parametrised, fully pipelined integer multiplier and multiply-accumulate unit for the Nios II datapath and for memory-mapped DSP helpers in the same system. It builds a DATA_W x DATA_W product from four half-width partial products, each operand independently signed or unsigned. An optional 2*DATA_W accumulator supports MAC operation. Either half of the result is returned over a valid/ready stream with in-order tags and full backpressure.

## Interface
- DATA_W, 32, operand/result width; even, 8..64; HALF_W = DATA_W/2 derived
- TAG_W, 4, width of the opaque tag carried alongside each operation
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_src1, in_src2  in  DATA_W  operands
- in_src1_signed, in_src2_signed  in  1  per-operand two's-complement flag
- in_op  in  2  00 MUL, 01 ACC_LOAD, 10 ACC_ADD, 11 reserved (treated as MUL)
- in_hi  in  1  1 = return upper DATA_W bits, 0 = lower
- in_tag  in  TAG_W  returned unchanged with result
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_result  out  DATA_W  selected half
- out_tag  out  TAG_W  tag of this result

## Operation
- Stage 1 (register S1): split operands into hi/lo halves; lo halves zero-extended, hi halves extended by their signed flag. Form p_ll = lo1*lo2, p_lh = lo1*hi2, p_hl = hi1*lo2, p_hh = hi1*hi2, each registered with op, hi, tag, valid.
- Stage 2 (register S2 = output): P = (p_hh << DATA_W) + ((p_lh + p_hl) << HALF_W) + p_ll, with p_lh/p_hl/p_hh sign-extended to 2*DATA_W. P is exactly src1*src2 of the extended operands, modulo 2^(2*DATA_W).
- MUL: R = P; accumulator unchanged.
- ACC_LOAD: acc <= P; R = P.
- ACC_ADD: acc <= acc + P, wrapping modulo 2^(2*DATA_W); R = new acc value.
- out_result = in_hi ? R[2*DATA_W-1:DATA_W] : R[DATA_W-1:0].
- Accumulator is updated only in stage 2, in issue order, so back-to-back ACC_ADDs chain without hazard.
- Global advance en = !out_valid || out_ready; S1 and S2 both load only when en. in_ready = en && !reset.
- Bubbles propagate: S1 valid loads in_valid && in_ready; S2 valid loads S1 valid.
- A bubble never modifies the accumulator. A stalled op modifies it exactly once, on the cycle it enters S2.

## Timing
- Latency 2: op accepted at edge N gives out_valid from edge N+2 when there is no stall.
- Throughput: one op per cycle while out_ready is held high.
- While out_valid && !out_ready: out_result, out_tag, out_valid hold stable; in_ready = 0; S1 contents held.
- Simultaneous out_ready and in_valid with a full pipe: output retires and new op is accepted in the same cycle.
- Reset values: out_valid 0, out_result 0, out_tag 0, in_ready 0 (during reset), S1/S2 valid 0, acc 0.
- Reset mid-operation discards all in-flight ops and clears acc. No result of a pre-reset op ever appears; in_ready is 1 the cycle after reset deasserts.

## Test plan
- DATA_W=32, unsigned 0xFFFFFFFF*0xFFFFFFFF, MUL -> hi=0 gives 0x00000001, hi=1 gives 0xFFFFFFFE; out_valid exactly 2 cycles after accept.
- Signed modes: s*s 0xFFFFFFFF*0xFFFFFFFF hi -> 0x00000000. s*u same operands hi -> 0xFFFFFFFF, lo -> 0x00000001. s*s 0x80000000*0x80000000 hi -> 0x40000000.
- Backpressure: 4 back-to-back MULs with tags 0..3 (k*3 for k=1..4), out_ready low 3 cycles mid-stream -> in_ready low while stalled; results 3,6,9,12 with tags 0..3 in order, none lost or duplicated.
- MAC: ACC_LOAD 3*4 -> 12; ACC_ADD 5*6 -> 42; ACC_ADD signed -2*7 -> 28; interleaved MUL 2*2 -> 4 leaves acc at 28 (next ACC_ADD 0*0 -> 28).
- Wrap: ACC_LOAD unsigned 0xFFFFFFFF*0xFFFFFFFF, ACC_ADD 0xFFFFFFFF*2, hi/lo -> 0xFFFFFFFF/0xFFFFFFFF; ACC_ADD 1*1 -> 0x00000000/0x00000000.
- Reset with 2 ops in flight and out_ready low -> out_valid 0 next cycle, acc 0 (ACC_ADD 1*1 after reset returns 1), no stale result.
